// File: rtl/p2s_tx_ctrl_if.sv
// Requester/serializer-side signal bundle for the p2s transmit link sequencer.
// The slave modport is the sequencer; the master modport drives it and consumes the lane outputs.
interface p2s_tx_ctrl_if;
    logic        IN_ENB_ctrl;
    logic        IN_VALID_req;
    logic [31:0] IN_DATA_req;
    logic        OUT_READY_req;
    logic [7:0]  OUT_LANE3;
    logic [7:0]  OUT_LANE2;
    logic [7:0]  OUT_LANE1;
    logic [7:0]  OUT_LANE0;
    logic [2:0]  OUT_CTR;
    logic        OUT_ENB;
    logic        OUT_VALID;
    logic        OUT_LINK_UP;

    modport slave (
        input  IN_ENB_ctrl, IN_VALID_req, IN_DATA_req,
        output OUT_READY_req, OUT_LANE3, OUT_LANE2, OUT_LANE1, OUT_LANE0,
        output OUT_CTR, OUT_ENB, OUT_VALID, OUT_LINK_UP
    );

    modport master (
        output IN_ENB_ctrl, IN_VALID_req, IN_DATA_req,
        input  OUT_READY_req, OUT_LANE3, OUT_LANE2, OUT_LANE1, OUT_LANE0,
        input  OUT_CTR, OUT_ENB, OUT_VALID, OUT_LINK_UP
    );
endinterface

// File: rtl/p2s_tx_ctrl.sv
// Transmit link sequencer: trains the 4-lane link with COM words, then forwards requester words,
// filling gaps with IDL and inserting one SKP word every SKIP_INTERVAL LINK cycles.
module p2s_tx_ctrl #(
    parameter int          TRAIN_COUNT   = 16,
    parameter int          SKIP_INTERVAL = 64,
    parameter logic [7:0]  SYM_COM       = 8'hBC,
    parameter logic [7:0]  SYM_SKP       = 8'h1C,
    parameter logic [7:0]  SYM_IDL       = 8'h7C
) (
    input  logic           IN_CLK_ctrl,
    input  logic           IN_RESET_ctrl,
    p2s_tx_ctrl_if.slave   bus
);
    localparam int TW = $clog2(TRAIN_COUNT + 1);
    localparam int SW = $clog2(SKIP_INTERVAL);
    localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_COUNT - 1);
    localparam logic [SW-1:0] SKIP_LAST  = SW'(SKIP_INTERVAL - 1);
    localparam logic [SW-1:0] SKIP_PRE   = SW'(SKIP_INTERVAL - 2);

    localparam logic [2:0] CTR_DATA = 3'b000;
    localparam logic [2:0] CTR_COM  = 3'b001;
    localparam logic [2:0] CTR_SKP  = 3'b010;
    localparam logic [2:0] CTR_IDL  = 3'b011;

    typedef enum logic [1:0] {ST_DISABLED, ST_TRAIN, ST_LINK, ST_SKIP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] train_cnt_q, train_cnt_d;
    logic [SW-1:0] skip_cnt_q, skip_cnt_d;
    logic [31:0]   word_q, word_d;
    logic [2:0]    ctr_q, ctr_d;
    logic          enb_q, enb_d;
    logic          valid_q, valid_d;
    logic          link_up_q, link_up_d;
    logic          ready;
    logic          accept;

    // The SKIP state is the cycle where skip_cnt sits at its terminal value, so ready is
    // low for exactly that one word slot per interval.
    assign ready  = bus.IN_ENB_ctrl && (state_q == ST_LINK) && (skip_cnt_q != SKIP_LAST);
    assign accept = ready && bus.IN_VALID_req;

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        skip_cnt_d  = skip_cnt_q;
        word_d      = 32'h0;
        ctr_d       = CTR_DATA;
        enb_d       = 1'b0;
        valid_d     = 1'b0;
        link_up_d   = 1'b0;

        if (!bus.IN_ENB_ctrl) begin
            state_d     = ST_DISABLED;
            train_cnt_d = '0;
            skip_cnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_DISABLED: begin
                    state_d     = ST_TRAIN;
                    train_cnt_d = '0;
                end
                ST_TRAIN: begin
                    word_d      = {4{SYM_COM}};
                    ctr_d       = CTR_COM;
                    enb_d       = 1'b1;
                    train_cnt_d = train_cnt_q + TW'(1);
                    if (train_cnt_q == TRAIN_LAST) begin
                        state_d    = ST_LINK;
                        skip_cnt_d = '0;
                    end
                end
                ST_LINK: begin
                    enb_d     = 1'b1;
                    link_up_d = 1'b1;
                    if (accept) begin
                        word_d  = bus.IN_DATA_req;
                        ctr_d   = CTR_DATA;
                        valid_d = 1'b1;
                    end else begin
                        word_d = {4{SYM_IDL}};
                        ctr_d  = CTR_IDL;
                    end
                    if (skip_cnt_q != SKIP_LAST) begin
                        skip_cnt_d = skip_cnt_q + SW'(1);
                    end
                    if (skip_cnt_q == SKIP_PRE) begin
                        state_d = ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    word_d     = {4{SYM_SKP}};
                    ctr_d      = CTR_SKP;
                    enb_d      = 1'b1;
                    link_up_d  = 1'b1;
                    skip_cnt_d = '0;
                    state_d    = ST_LINK;
                end
                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end
    end

    always_ff @(posedge IN_CLK_ctrl or negedge IN_RESET_ctrl) begin
        if (!IN_RESET_ctrl) begin
            state_q     <= ST_DISABLED;
            train_cnt_q <= '0;
            skip_cnt_q  <= '0;
            word_q      <= 32'h0;
            ctr_q       <= CTR_DATA;
            enb_q       <= 1'b0;
            valid_q     <= 1'b0;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
            skip_cnt_q  <= skip_cnt_d;
            word_q      <= word_d;
            ctr_q       <= ctr_d;
            enb_q       <= enb_d;
            valid_q     <= valid_d;
            link_up_q   <= link_up_d;
        end
    end

    assign bus.OUT_READY_req = ready;
    assign bus.OUT_LANE3     = word_q[31:24];
    assign bus.OUT_LANE2     = word_q[23:16];
    assign bus.OUT_LANE1     = word_q[15:8];
    assign bus.OUT_LANE0     = word_q[7:0];
    assign bus.OUT_CTR       = ctr_q;
    assign bus.OUT_ENB       = enb_q;
    assign bus.OUT_VALID     = valid_q;
    assign bus.OUT_LINK_UP   = link_up_q;
endmodule

// File: tb/tb_p2s_tx_ctrl.sv
// Directed bench for p2s_tx_ctrl: reset, training, data, skip insertion, enable drop, mid-stream reset.
`timescale 1ns/1ps
module tb_p2s_tx_ctrl;
    localparam int TRAIN_COUNT   = 16;
    localparam int SKIP_INTERVAL = 64;
    localparam logic [2:0] C_DATA = 3'b000;
    localparam logic [2:0] C_COM  = 3'b001;
    localparam logic [2:0] C_SKP  = 3'b010;
    localparam logic [2:0] C_IDL  = 3'b011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    p2s_tx_ctrl_if bus();

    p2s_tx_ctrl #(
        .TRAIN_COUNT  (TRAIN_COUNT),
        .SKIP_INTERVAL(SKIP_INTERVAL)
    ) dut (
        .IN_CLK_ctrl  (clk),
        .IN_RESET_ctrl(rst_n),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;
    int pos    = 0;          // index of the LINK/SKIP cycle currently in progress
    logic [31:0] seq;

    // {lane3,lane2,lane1,lane0,ctr,enb,valid,link_up}
    function automatic logic [37:0] outs();
        return {bus.OUT_LANE3, bus.OUT_LANE2, bus.OUT_LANE1, bus.OUT_LANE0,
                bus.OUT_CTR, bus.OUT_ENB, bus.OUT_VALID, bus.OUT_LINK_UP};
    endfunction

    function automatic logic [37:0] mk(input logic [31:0] w, input logic [2:0] c,
                                       input logic e, input logic v, input logic l);
        return {w, c, e, v, l};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        pos++;
    endtask

    // Waits for the first COM, then expects TRAIN_COUNT consecutive COM words; leaves pos=0.
    task automatic run_train(input string tag);
        int waited = 0;
        int n = 0;
        bit leak = 1'b0;
        bit bad_rdy = 1'b0;
        bit go = 1'b1;
        while (bus.OUT_CTR !== C_COM && waited < 4) begin
            if (bus.OUT_READY_req !== 1'b0) bad_rdy = 1'b1;
            cycle();
            waited++;
            if (bus.OUT_VALID !== 1'b0) leak = 1'b1;
        end
        checks++;
        if (bus.OUT_CTR !== C_COM || waited > 2) begin
            errors++;
            $display("FAIL %s_first_com: ctr=%b after %0d edges, required 001 within 2 edges", tag, bus.OUT_CTR, waited);
        end
        checks++;
        if (leak) begin
            errors++;
            $display("FAIL %s_no_leak: valid seen before training, required none", tag);
        end
        if (bus.OUT_CTR === C_COM) n = 1;
        while (go && n < TRAIN_COUNT) begin
            if (bus.OUT_READY_req !== 1'b0) bad_rdy = 1'b1;
            cycle();
            if (outs() === mk({4{8'hBC}}, C_COM, 1'b1, 1'b0, 1'b0)) n++;
            else go = 1'b0;
        end
        checks++;
        if (n != TRAIN_COUNT) begin
            errors++;
            $display("FAIL %s_com_count: got %0d COM words, required %0d", tag, n, TRAIN_COUNT);
        end
        checks++;
        if (bad_rdy) begin
            errors++;
            $display("FAIL %s_ready_low: ready seen high before LINK, required 0", tag);
        end
        $display("%s: %0d COM words", tag, n);
        pos = 0;
    endtask

    task automatic test_reset();
        bus.IN_ENB_ctrl  = 1'b1;
        bus.IN_VALID_req = 1'b1;
        bus.IN_DATA_req  = 32'hDEADBEEF;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs() !== 38'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required %h", outs(), 38'h0);
        end
        checks++;
        if (bus.OUT_READY_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b required 0", bus.OUT_READY_req);
        end
        $display("reset: outputs=%h ready=%b", outs(), bus.OUT_READY_req);
        rst_n = 1'b1;
        bus.IN_VALID_req = 1'b0;
    endtask

    task automatic test_train();
        run_train("train");
        cycle();
        checks++;
        if (outs() !== mk({4{8'h7C}}, C_IDL, 1'b1, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL train_then_idle: got %h required %h", outs(), mk({4{8'h7C}}, C_IDL, 1'b1, 1'b0, 1'b1));
        end
        $display("link: first word %h", outs());
    endtask

    task automatic test_data();
        bus.IN_DATA_req  = 32'hDEADBEEF;
        bus.IN_VALID_req = 1'b1;
        #1;
        checks++;
        if (bus.OUT_READY_req !== 1'b1) begin
            errors++;
            $display("FAIL data_ready: got %b required 1", bus.OUT_READY_req);
        end
        cycle();
        bus.IN_VALID_req = 1'b0;
        checks++;
        if (outs() !== mk(32'hDEADBEEF, C_DATA, 1'b1, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL data_word: got %h required %h", outs(), mk(32'hDEADBEEF, C_DATA, 1'b1, 1'b1, 1'b1));
        end
        $display("data: lanes %h %h %h %h ctr=%b", bus.OUT_LANE3, bus.OUT_LANE2, bus.OUT_LANE1, bus.OUT_LANE0, bus.OUT_CTR);
        cycle();
        checks++;
        if (outs() !== mk({4{8'h7C}}, C_IDL, 1'b1, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL data_then_idle: got %h required %h", outs(), mk({4{8'h7C}}, C_IDL, 1'b1, 1'b0, 1'b1));
        end
    endtask

    task automatic test_skip();
        int n_skp = 0;
        int p;
        logic exp_rdy;
        seq = 32'h1000_0000;
        bus.IN_DATA_req  = seq;
        bus.IN_VALID_req = 1'b1;
        for (int i = 0; i < 140; i++) begin
            p = pos;
            exp_rdy = ((p % SKIP_INTERVAL) != SKIP_INTERVAL - 1);
            checks++;
            if (bus.OUT_READY_req !== exp_rdy) begin
                errors++;
                $display("FAIL skip_ready pos %0d: got %b required %b", p, bus.OUT_READY_req, exp_rdy);
            end
            cycle();
            checks++;
            if (!exp_rdy) begin
                n_skp++;
                if (outs() !== mk({4{8'h1C}}, C_SKP, 1'b1, 1'b0, 1'b1)) begin
                    errors++;
                    $display("FAIL skip_word pos %0d: got %h required %h", p, outs(), mk({4{8'h1C}}, C_SKP, 1'b1, 1'b0, 1'b1));
                end
                $display("stream pos %0d: SKP ctr=%b", p, bus.OUT_CTR);
            end else begin
                if (outs() !== mk(seq, C_DATA, 1'b1, 1'b1, 1'b1)) begin
                    errors++;
                    $display("FAIL stream_word pos %0d: got %h required %h", p, outs(), mk(seq, C_DATA, 1'b1, 1'b1, 1'b1));
                end
                $display("stream pos %0d: data %h", p, {bus.OUT_LANE3, bus.OUT_LANE2, bus.OUT_LANE1, bus.OUT_LANE0});
                seq = seq + 32'd1;
                bus.IN_DATA_req = seq;
            end
        end
        checks++;
        if (n_skp != 2) begin
            errors++;
            $display("FAIL skip_count: got %0d SKP words, required 2", n_skp);
        end
    endtask

    task automatic test_enb_drop();
        bus.IN_ENB_ctrl = 1'b0;
        #1;
        checks++;
        if (bus.OUT_READY_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_ready: got %b required 0", bus.OUT_READY_req);
        end
        cycle();
        checks++;
        if (outs() !== 38'h0) begin
            errors++;
            $display("FAIL drop_outputs: got %h required %h", outs(), 38'h0);
        end
        $display("enable drop: outputs=%h", outs());
        bus.IN_ENB_ctrl = 1'b1;
        run_train("retrain");
        checks++;
        if (bus.OUT_READY_req !== 1'b1) begin
            errors++;
            $display("FAIL retrain_ready: got %b required 1", bus.OUT_READY_req);
        end
        cycle();
        checks++;
        if (outs() !== mk(seq, C_DATA, 1'b1, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL retrain_resume: got %h required %h", outs(), mk(seq, C_DATA, 1'b1, 1'b1, 1'b1));
        end
        $display("resume: data %h", {bus.OUT_LANE3, bus.OUT_LANE2, bus.OUT_LANE1, bus.OUT_LANE0});
        seq = seq + 32'd1;
        bus.IN_DATA_req = seq;
    endtask

    task automatic test_reset_mid();
        #1;
        checks++;
        if (bus.OUT_READY_req !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready_before: got %b required 1", bus.OUT_READY_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 38'h0) begin
            errors++;
            $display("FAIL midrst_async_clear: got %h required %h", outs(), 38'h0);
        end
        checks++;
        if (bus.OUT_READY_req !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready: got %b required 0", bus.OUT_READY_req);
        end
        $display("mid-stream reset: outputs=%h", outs());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_train("reset_retrain");
        bus.IN_VALID_req = 1'b0;
        cycle();
        checks++;
        if (outs() !== mk({4{8'h7C}}, C_IDL, 1'b1, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL midrst_idle: got %h required %h", outs(), mk({4{8'h7C}}, C_IDL, 1'b1, 1'b0, 1'b1));
        end
    endtask

    initial begin
        bus.IN_ENB_ctrl  = 1'b0;
        bus.IN_VALID_req = 1'b0;
        bus.IN_DATA_req  = 32'h0;
        test_reset();
        test_train();
        test_data();
        test_skip();
        test_enb_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
